// File: rtl/cpc_ram_pkg.sv
// Shared constants and types for the CPC RAM banking controller.
// Holds the mode encodings, the I/O-write capture FSM states and the port decode masks.
package cpc_ram_pkg;

  localparam int MAX_BANK_BITS = 6;

  localparam logic [2:0] MODE_0 = 3'd0;
  localparam logic [2:0] MODE_1 = 3'd1;
  localparam logic [2:0] MODE_2 = 3'd2;
  localparam logic [2:0] MODE_3 = 3'd3;
  localparam logic [2:0] MODE_4 = 3'd4;
  localparam logic [2:0] MODE_5 = 3'd5;
  localparam logic [2:0] MODE_6 = 3'd6;
  localparam logic [2:0] MODE_7 = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILT = 2'd1,
    HOLD = 2'd2
  } iow_state_e;

  // Gate-array RAM-config port: A15 low, data bits 7:6 set to 11.
  localparam logic [15:0] IOW_PORT_MASK  = 16'h8000;
  localparam logic [15:0] IOW_PORT_MATCH = 16'h0000;
  localparam logic [7:0]  IOW_DATA_MASK  = 8'hC0;
  localparam logic [7:0]  IOW_DATA_MATCH = 8'hC0;

endpackage

// File: rtl/cpc_iow_capture.sv
// Filters the RAM-config I/O-write condition and emits one capture strobe per I/O cycle.
// The strobe is combinational so the configuration registers load on that same edge.
module cpc_iow_capture
  import cpc_ram_pkg::*;
#(
  parameter int IOW_FILTER = 1
) (
  input  logic clk,
  input  logic reset_b,
  input  logic iow_hit,
  input  logic ioreq_b,
  output logic capture
);

  localparam logic [1:0] FILT_LAST = 2'(IOW_FILTER);

  generate
    if (IOW_FILTER < 1 || IOW_FILTER > 3) begin : g_bad_filter
      $error("cpc_iow_capture: IOW_FILTER must be 1..3");
    end
  endgenerate

  iow_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] cnt_inc;

  assign cnt_inc = cnt_q + 2'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (iow_hit) begin
          cnt_d = 2'd1;
          if (FILT_LAST == 2'd1) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = FILT;
          end
        end
      end
      FILT: begin
        if (!iow_hit) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == FILT_LAST) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Stay put until the I/O cycle ends so a long write captures once.
        if (ioreq_b) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cpc_ram_bank_ctrl.sv
// CPC RAM expansion banking controller: captures gate-array RAM-config writes and maps SRAM.
// Define CPC_RAM_WPROT_EN to let dip1 write-protect the whole expansion.
module cpc_ram_bank_ctrl
  import cpc_ram_pkg::*;
#(
  parameter int BANK_BITS  = 3,
  parameter int IOW_FILTER = 1,
  parameter int HIADR_W    = BANK_BITS + 2
) (
  input  logic               CLK,
  input  logic               RESET_B,
  input  logic [15:0]        A,
  input  logic [7:0]         D,
  input  logic               MREQ_B,
  input  logic               IOREQ_B,
  input  logic               WR_B,
  input  logic               RFSH_B,
  input  logic               M1_B,
  input  logic               dip0,
  input  logic               dip1,
  output logic [HIADR_W-1:0] HIADR,
  output logic               RAMCS_B,
  output logic               RAMWE_B,
  output logic               RAMDIS
);

  generate
    if (BANK_BITS < 3 || BANK_BITS > MAX_BANK_BITS) begin : g_bad_bank
      $error("cpc_ram_bank_ctrl: BANK_BITS must be 3..6");
    end
  endgenerate

  logic                 iow_hit;
  logic                 capture;
  logic [2:0]           cfg_mode_q, cfg_mode_d;
  logic [BANK_BITS-1:0] cfg_bank_q, cfg_bank_d;
  logic [BANK_BITS-1:0] new_bank;
  logic [1:0]           blk;
  logic [1:0]           page;
  logic                 in_map;
  logic                 mapped;
  logic                 wp;

  assign iow_hit = ~IOREQ_B & ~WR_B & M1_B
                 & ((A & IOW_PORT_MASK) == IOW_PORT_MATCH)
                 & ((D & IOW_DATA_MASK) == IOW_DATA_MATCH);

  cpc_iow_capture #(
    .IOW_FILTER(IOW_FILTER)
  ) u_capture (
    .clk     (CLK),
    .reset_b (RESET_B),
    .iow_hit (iow_hit),
    .ioreq_b (IOREQ_B),
    .capture (capture)
  );

  // Extra bank bits come from the inverted high port address lines.
  generate
    if (BANK_BITS > 3) begin : g_wide_bank
      assign new_bank = {~A[8 +: BANK_BITS-3], D[5:3]};
    end else begin : g_base_bank
      assign new_bank = D[5:3];
    end
  endgenerate

  always_comb begin
    cfg_mode_d = cfg_mode_q;
    cfg_bank_d = cfg_bank_q;
    if (capture) begin
      cfg_mode_d = D[2:0];
      cfg_bank_d = new_bank;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      cfg_mode_q <= MODE_0;
      cfg_bank_q <= '0;
    end else begin
      cfg_mode_q <= cfg_mode_d;
      cfg_bank_q <= cfg_bank_d;
    end
  end

  assign blk = A[15:14];

  always_comb begin
    in_map = 1'b0;
    page   = 2'd0;
    case (cfg_mode_q)
      MODE_1, MODE_3: begin
        if (blk == 2'd3) begin
          in_map = 1'b1;
          page   = 2'd3;
        end
      end
      MODE_2: begin
        in_map = 1'b1;
        page   = blk;
      end
      MODE_4, MODE_5, MODE_6, MODE_7: begin
        if (blk == 2'd1) begin
          in_map = 1'b1;
          page   = cfg_mode_q[1:0];
        end
      end
      default: begin
        in_map = 1'b0;
        page   = 2'd0;
      end
    endcase
  end

`ifdef CPC_RAM_WPROT_EN
  assign wp = dip1;
`else
  logic unused_dip1;
  assign unused_dip1 = dip1;
  assign wp          = 1'b0;
`endif

  assign mapped  = dip0 & in_map & ~MREQ_B & RFSH_B;
  assign HIADR   = {cfg_bank_q, page};
  assign RAMCS_B = ~mapped;
  assign RAMDIS  = mapped;
  assign RAMWE_B = ~(mapped & ~WR_B & ~wp);

endmodule

// File: doc/cpc_ram_bank_ctrl.md
Name: cpc_ram_bank_ctrl

Overview:
- Parametrised CPLD-resident RAM banking controller for CPC RAM expansion boards.
- Decodes CPC gate-array RAM-config I/O writes (port &7Fxx, D7:6=11) into a registered bank/mode configuration.
- Drives SRAM high address bits, chip select and write strobe, and asserts RAMDIS to the CPC for expansion-mapped accesses.
- Generalises the fixed 512K board to 512K/1M/2M/4M via extra bank bits taken from inverted port address lines A10:8.

Parameters:
- BANK_BITS, 3, 64K-bank select width; 3 gives 512K, max 6 gives 4M.
- IOW_FILTER, 1, consecutive CLK samples for which the I/O-write condition must hold before capture (1..3).
- HIADR_W, BANK_BITS+2, SRAM address bits above A13 (derived; do not override).

Ports:
- CLK  in  1  CPC 4 MHz bus clock.
- RESET_B  in  1  synchronous active-low reset, sampled on CLK rising edge.
- A  in  16  Z80 address bus.
- D  in  8  Z80 data bus (input only).
- MREQ_B  in  1  memory request.
- IOREQ_B  in  1  I/O request.
- WR_B  in  1  write strobe.
- RFSH_B  in  1  refresh cycle.
- M1_B  in  1  opcode fetch / interrupt acknowledge.
- dip0  in  1  1 = expansion enabled.
- dip1  in  1  write-protect select (see Optional Feature).
- HIADR  out  HIADR_W  SRAM A[14+HIADR_W-1:14].
- RAMCS_B  out  1  SRAM chip select.
- RAMWE_B  out  1  SRAM write enable.
- RAMDIS  out  1  disables CPC internal RAM.

Behaviour:
- Reset: RESET_B low at a CLK edge clears cfg_bank=0, cfg_mode=0, FSM=IDLE. With mode 0 the outputs are RAMCS_B=1, RAMWE_B=1, RAMDIS=0, HIADR=0.
- Reset mid-access or mid-capture: the pending capture is discarded.
- iow_hit (combinational) = ~IOREQ_B & ~WR_B & M1_B & ~A15 & D7 & D6.
- FSM states:
  - IDLE: on iow_hit, go to FILT with cnt=1. If IOW_FILTER=1, capture immediately and go to HOLD.
  - FILT: while iow_hit holds, increment cnt; when cnt==IOW_FILTER, capture and go to HOLD. If iow_hit drops, return to IDLE with no capture.
  - HOLD: wait for IOREQ_B=1, then go to IDLE. This gives exactly one capture per I/O cycle.
- Capture: cfg_mode<=D2:0; cfg_bank<={~A[8+:BANK_BITS-3], D5:3}. For BANK_BITS=3 only D5:3 is used.
- Capture latency: new cfg takes effect from the CLK edge IOW_FILTER cycles after iow_hit is first seen.
- Address decode is combinational from registered cfg. blk=A15:14. Mapped page p:
  - mode 0: none mapped.
  - mode 1: blk3 maps to p=3.
  - mode 2: blk0..3 map to p=blk.
  - mode 3: blk3 maps to p=3.
  - modes 4..7: blk1 maps to p=mode-4.
- mapped = dip0 & (blk in map) & ~MREQ_B & RFSH_B.
- Output equations:
  - HIADR={cfg_bank, p[1:0]}.
  - RAMCS_B=~mapped.
  - RAMDIS=mapped.
  - RAMWE_B=~(mapped & ~WR_B & ~wp), where wp is 0 unless the Optional Feature applies.
- Refresh cycles (RFSH_B=0) are never mapped.
- I/O writes with A15=1, or with D7:6 other than 11, are ignored.
- A memory access during a capture edge uses the old cfg until the capture edge, then the new cfg.

Optional Feature:
- Macro: CPC_RAM_WPROT_EN.
- Defined: dip1=1 write-protects all expansion RAM. RAMWE_B stays 1; RAMCS_B and RAMDIS behave normally, so writes are swallowed and the data bus is not driven.
- Undefined: dip1 is ignored and wp=0.

Decomposition:
- Package cpc_ram_pkg holds:
  - mode encoding localparams MODE_0..MODE_7;
  - the FSM state typedef (IDLE, FILT, HOLD);
  - MAX_BANK_BITS=6;
  - IOW_PORT_MASK constants.
- One natural sub-module, cpc_iow_capture: the FSM plus filter counter, outputting a one-cycle capture strobe.
- Bank/page decode stays in the top level.

Test Plan:
- Reset then OUT &7F,&C2 (D=8'hC2, A=16'h7FC2, BANK_BITS=3): after the capture edge, reads at &0000, &4000, &8000 and &C000 give RAMCS_B=0, RAMDIS=1, and HIADR=0,1,2,3 respectively.
- BANK_BITS=6, OUT A=16'h7C00, D=8'hFD (bank D5:3=7, A10:8=100 inverted to 011): access at &4000 gives HIADR=8'b011111_01 (bank 31, page 1).
- IOW_FILTER=2, a 1-cycle iow_hit glitch: cfg unchanged. iow_hit held 4 cycles: exactly one capture, on the second cycle.
- Mode 1 active, a refresh cycle at &C000 (RFSH_B=0, MREQ_B=0): RAMCS_B=1, RAMDIS=0. An M1_B=0 I/O cycle with D=8'hC7: no capture.
- RESET_B low for one CLK during an active mode-2 write: the next cycle gives RAMCS_B=1, RAMWE_B=1, RAMDIS=0, HIADR=0.
- CPC_RAM_WPROT_EN defined, dip1=1, mode 2, write to &8000: RAMCS_B=0, RAMDIS=1, RAMWE_B stays 1. With dip1=0: RAMWE_B=0 while WR_B=0.
